// File: rtl/pck_regfile.sv
// rtl/pck_regfile.sv - register file shared types: writeback entry, source id, zero address
package pck_regfile;

  localparam logic [4:0] RF_ADDR_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/cpu_wb_fifo.sv
// rtl/cpu_wb_fifo.sv - writeback entry FIFO exposing all slots, read pointer and valid vector
module cpu_wb_fifo
  import pck_regfile::*;
#(
  parameter  int p_depth = 4,
  localparam int AW      = $clog2(p_depth),
  localparam int LW      = AW + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  wb_entry_t                   i_push_entry,
  input  logic                        i_pop,
  output wb_entry_t [p_depth-1:0]     o_entries,
  output logic      [p_depth-1:0]     o_valid,
  output logic      [AW-1:0]          o_rd_ptr,
  output logic                        o_full,
  output logic                        o_empty,
  output logic      [LW-1:0]          o_level
);

  wb_entry_t [p_depth-1:0] r_mem;
  logic      [AW-1:0]      r_wr_ptr;
  logic      [AW-1:0]      r_rd_ptr;
  logic      [LW-1:0]      r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the level
  always_comb begin
    o_valid = '0;
    for (int i = 0; i < p_depth; i++) begin
      logic [AW-1:0] w_off;
      w_off      = AW'(i) - r_rd_ptr;
      o_valid[i] = ({1'b0, w_off} < r_level);
    end
  end

  assign o_entries = r_mem;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_level   = r_level;
  assign o_full    = (r_level == LW'(p_depth));
  assign o_empty   = (r_level == '0);

endmodule

// File: rtl/cpu_regfile_wb_ctrl.sv
// rtl/cpu_regfile_wb_ctrl.sv - regfile writeback arbiter, buffer, drain and hazard detect
// Optional operand forwarding is built when ASTERISC_WB_FWD_EN is defined.
module cpu_regfile_wb_ctrl
  import pck_regfile::*;
#(
  parameter  int p_fifo_depth   = 4,
  parameter  int p_half_regfile = 0,
  localparam int AW             = $clog2(p_fifo_depth),
  localparam int LW             = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_alu_valid,
  output logic          o_alu_ready,
  input  logic [4:0]    i_alu_addr,
  input  logic [31:0]   i_alu_data,
  input  logic          i_lsu_valid,
  output logic          o_lsu_ready,
  input  logic [4:0]    i_lsu_addr,
  input  logic [31:0]   i_lsu_data,
  input  logic          i_rf_busy,
  output logic          o_wr_en,
  output logic [4:0]    o_wr_addr,
  output logic [31:0]   o_wr_data,
  input  logic [4:0]    i_rd1_addr,
  input  logic [4:0]    i_rd2_addr,
  output logic          o_rd1_pending,
  output logic          o_rd2_pending,
  output logic [31:0]   o_rd1_fwd_data,
  output logic [31:0]   o_rd2_fwd_data,
  output logic          o_addr_oob,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  wb_entry_t [p_fifo_depth-1:0] w_entries;
  logic      [p_fifo_depth-1:0] w_valid;
  logic      [AW-1:0]           w_rd_ptr;
  logic                         w_full;
  logic                         w_empty;
  wb_src_t                      w_src;
  wb_entry_t                    w_req;
  wb_entry_t                    w_head;
  logic                         w_accept;
  logic                         w_oob;
  logic                         w_push;
  logic                         w_pop;
  logic                         r_addr_oob;

  // LSU wins; ready depends only on registered occupancy, not on a same-cycle pop
  assign o_lsu_ready = !w_full;
  assign o_alu_ready = !w_full && !i_lsu_valid;

  assign w_src    = i_lsu_valid ? WB_SRC_LSU : WB_SRC_ALU;
  assign w_req    = (w_src == WB_SRC_LSU) ? '{addr: i_lsu_addr, data: i_lsu_data}
                                          : '{addr: i_alu_addr, data: i_alu_data};
  assign w_accept = (i_lsu_valid || i_alu_valid) && !w_full;
  assign w_oob    = (p_half_regfile != 0) && w_req.addr[4];
  assign w_push   = w_accept && (w_req.addr != RF_ADDR_ZERO) && !w_oob;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_oob <= 1'b0;
    end else begin
      r_addr_oob <= w_accept && w_oob;
    end
  end

  cpu_wb_fifo #(
    .p_depth (p_fifo_depth)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (w_push),
    .i_push_entry (w_req),
    .i_pop        (w_pop),
    .o_entries    (w_entries),
    .o_valid      (w_valid),
    .o_rd_ptr     (w_rd_ptr),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_level      (o_level)
  );

  assign w_head    = w_entries[w_rd_ptr];
  assign w_pop     = !w_empty && !i_rf_busy;
  assign o_wr_en   = w_pop;
  assign o_wr_addr = w_empty ? RF_ADDR_ZERO : w_head.addr;
  assign o_wr_data = w_empty ? 32'd0 : w_head.data;
  assign o_empty   = w_empty;
  assign o_addr_oob = r_addr_oob;

  always_comb begin
    o_rd1_pending = 1'b0;
    o_rd2_pending = 1'b0;
    for (int i = 0; i < p_fifo_depth; i++) begin
      if (w_valid[i] && (i_rd1_addr != RF_ADDR_ZERO) && (w_entries[i].addr == i_rd1_addr))
        o_rd1_pending = 1'b1;
      if (w_valid[i] && (i_rd2_addr != RF_ADDR_ZERO) && (w_entries[i].addr == i_rd2_addr))
        o_rd2_pending = 1'b1;
    end
  end

`ifdef ASTERISC_WB_FWD_EN
  // Walk oldest to newest so the last match, the newest write, wins
  always_comb begin
    o_rd1_fwd_data = 32'd0;
    o_rd2_fwd_data = 32'd0;
    for (int k = 0; k < p_fifo_depth; k++) begin
      logic [AW-1:0] w_idx;
      w_idx = w_rd_ptr + AW'(k);
      if (w_valid[w_idx] && (i_rd1_addr != RF_ADDR_ZERO) && (w_entries[w_idx].addr == i_rd1_addr))
        o_rd1_fwd_data = w_entries[w_idx].data;
      if (w_valid[w_idx] && (i_rd2_addr != RF_ADDR_ZERO) && (w_entries[w_idx].addr == i_rd2_addr))
        o_rd2_fwd_data = w_entries[w_idx].data;
    end
  end
`else
  assign o_rd1_fwd_data = 32'd0;
  assign o_rd2_fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_regfile_wb_ctrl.sv
// tb/tb_cpu_regfile_wb_ctrl.sv - directed self-checking bench for cpu_regfile_wb_ctrl
module tb_cpu_regfile_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, lsu_valid, rf_busy;
  logic          alu_ready, lsu_ready;
  logic [4:0]    alu_addr, lsu_addr, rd1_addr, rd2_addr;
  logic [31:0]   alu_data, lsu_data;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          rd1_pending, rd2_pending;
  logic [31:0]   rd1_fwd, rd2_fwd;
  logic          addr_oob, empty;
  logic [LW-1:0] level;
  logic [31:0]   exp_fwd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_regfile_wb_ctrl #(
    .p_fifo_depth   (DEPTH),
    .p_half_regfile (1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_alu_valid    (alu_valid),
    .o_alu_ready    (alu_ready),
    .i_alu_addr     (alu_addr),
    .i_alu_data     (alu_data),
    .i_lsu_valid    (lsu_valid),
    .o_lsu_ready    (lsu_ready),
    .i_lsu_addr     (lsu_addr),
    .i_lsu_data     (lsu_data),
    .i_rf_busy      (rf_busy),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .i_rd1_addr     (rd1_addr),
    .i_rd2_addr     (rd2_addr),
    .o_rd1_pending  (rd1_pending),
    .o_rd2_pending  (rd2_pending),
    .o_rd1_fwd_data (rd1_fwd),
    .o_rd2_fwd_data (rd2_fwd),
    .o_addr_oob     (addr_oob),
    .o_empty        (empty),
    .o_level        (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 0; lsu_valid = 0; rf_busy = 0;
    alu_addr = 0; alu_data = 0; lsu_addr = 0; lsu_data = 0;
    rd1_addr = 0; rd2_addr = 0;
    #2;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_oob", {31'd0, addr_oob}, 32'd0);
    check("rst_pend", {30'd0, rd1_pending, rd2_pending}, 32'd0);
    check("rst_fwd", rd1_fwd | rd2_fwd, 32'd0);
    cyc(); rst_n = 1'b1;

    // Single ALU write: presented the cycle after acceptance, gone the cycle after that
    cyc(); alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF; rd1_addr = 5'd5; #1;
    check("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("t1_wr_en_c0", {31'd0, wr_en}, 32'd0);
    cyc(); alu_valid = 0; #1;
    check("t1_wr_en", {31'd0, wr_en}, 32'd1);
    check("t1_wr_addr", {27'd0, wr_addr}, 32'd5);
    check("t1_wr_data", wr_data, 32'hDEADBEEF);
    check("t1_pend", {31'd0, rd1_pending}, 32'd1);
    cyc(); #1;
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_wr_en_c2", {31'd0, wr_en}, 32'd0);
    check("t1_pend_clr", {31'd0, rd1_pending}, 32'd0);
    rd1_addr = 0;

    // LSU beats ALU; write order 4 then 3
    cyc(); alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h33;
    lsu_valid = 1; lsu_addr = 5'd4; lsu_data = 32'h44; #1;
    check("t2_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("t2_alu_ready", {31'd0, alu_ready}, 32'd0);
    cyc(); lsu_valid = 0; #1;
    check("t2_alu_ready2", {31'd0, alu_ready}, 32'd1);
    check("t2_first_addr", {27'd0, wr_addr}, 32'd4);
    check("t2_first_data", wr_data, 32'h44);
    cyc(); alu_valid = 0; #1;
    check("t2_second_addr", {27'd0, wr_addr}, 32'd3);
    check("t2_second_en", {31'd0, wr_en}, 32'd1);
    check("t2_level", {{(32-LW){1'b0}}, level}, 32'd1);
    cyc(); #1;
    check("t2_empty", {31'd0, empty}, 32'd1);

    // Busy regfile: fill to full, then drain four in order
    rf_busy = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); alu_valid = 1; alu_addr = 5'(8 + i); alu_data = 32'h100 + 32'(i); #1;
      check("t3_fill_ready", {31'd0, alu_ready}, 32'd1);
    end
    cyc(); #1;
    check("t3_level", {{(32-LW){1'b0}}, level}, 32'd4);
    check("t3_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("t3_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    check("t3_wr_en_busy", {31'd0, wr_en}, 32'd0);
    alu_valid = 0; rf_busy = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      check("t3_drain_en", {31'd0, wr_en}, 32'd1);
      check("t3_drain_addr", {27'd0, wr_addr}, 32'(8 + i));
      check("t3_drain_data", wr_data, 32'h100 + 32'(i));
    end
    cyc(); #1;
    check("t3_empty", {31'd0, empty}, 32'd1);

    // Address 0 is swallowed; address 17 is out of bounds on a 16-entry regfile
    cyc(); alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hAA; #1;
    check("t4_zero_ready", {31'd0, alu_ready}, 32'd1);
    cyc(); alu_valid = 0; lsu_valid = 1; lsu_addr = 5'd17; lsu_data = 32'hBB; #1;
    check("t4_zero_level", {{(32-LW){1'b0}}, level}, 32'd0);
    check("t4_zero_wr_en", {31'd0, wr_en}, 32'd0);
    check("t4_zero_oob", {31'd0, addr_oob}, 32'd0);
    check("t4_oob_ready", {31'd0, lsu_ready}, 32'd1);
    cyc(); lsu_valid = 0; #1;
    check("t4_oob_pulse", {31'd0, addr_oob}, 32'd1);
    check("t4_oob_level", {{(32-LW){1'b0}}, level}, 32'd0);
    cyc(); #1;
    check("t4_oob_clear", {31'd0, addr_oob}, 32'd0);

    // Two writes to r7: pending until the second drains, newest data forwarded
`ifdef ASTERISC_WB_FWD_EN
    exp_fwd = 32'h2;
`else
    exp_fwd = 32'h0;
`endif
    rf_busy = 1; rd1_addr = 5'd7; rd2_addr = 5'd9;
    cyc(); alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h1;
    cyc(); alu_data = 32'h2;
    cyc(); alu_valid = 0; #1;
    check("t5_pend1", {31'd0, rd1_pending}, 32'd1);
    check("t5_pend2", {31'd0, rd2_pending}, 32'd0);
    check("t5_fwd1", rd1_fwd, exp_fwd);
    rf_busy = 0; #1;
    check("t5_drain_first", wr_data, 32'h1);
    cyc(); #1;
    check("t5_pend_mid", {31'd0, rd1_pending}, 32'd1);
    check("t5_fwd_mid", rd1_fwd, exp_fwd);
    cyc(); #1;
    check("t5_pend_done", {31'd0, rd1_pending}, 32'd0);
    rd1_addr = 0; rd2_addr = 0;

    // Asynchronous reset with three entries queued
    rf_busy = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); alu_valid = 1; alu_addr = 5'(1 + i); alu_data = 32'(i);
    end
    cyc(); alu_valid = 0; rd1_addr = 5'd2; #1;
    check("t6_pre_level", {{(32-LW){1'b0}}, level}, 32'd3);
    #1; rf_busy = 0; rst_n = 0; #1;
    check("t6_wr_en", {31'd0, wr_en}, 32'd0);
    check("t6_empty", {31'd0, empty}, 32'd1);
    check("t6_level", {{(32-LW){1'b0}}, level}, 32'd0);
    check("t6_pend", {31'd0, rd1_pending}, 32'd0);
    cyc(); rst_n = 1;
    cyc(); #1;
    check("t6_after", {31'd0, wr_en}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
